// File: rtl/alu_arbiter_if.sv
// Requester-side bus for alu_arbiter: NREQ request channels (valid/ready plus
// aluop and operands) and NREQ buffered response channels (valid/ready plus
// result and {overflow, negative, zero} flags).
//   master : requester side (drives requests, consumes responses)
//   slave  : arbiter side   (grants requests, produces responses)
interface alu_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][3:0]  req_aluop;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [NREQ-1:0][31:0] rsp_o;
  logic [NREQ-1:0][2:0]  rsp_flags;

  modport master (
    output req_valid, req_aluop, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_o, rsp_flags
  );

  modport slave (
    input  req_valid, req_aluop, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_o, rsp_flags
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// One operation is issued per cycle; the ALU result is captured into a
// per-requester response buffer, giving one cycle of latency to rsp_valid.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   bus (slave)       request/response channels, see alu_arbiter_if
//   alu_aluop/port_a/port_b  operation driven to the shared ALU
//   alu_port_o, alu_flag_*   ALU result and flags, sampled in the same cycle
//   stall_cnt         saturating count of cycles with a valid, ungranted request
module alu_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  alu_arbiter_if.slave      bus,
  output logic [3:0]        alu_aluop,
  output logic [31:0]       alu_port_a,
  output logic [31:0]       alu_port_b,
  input  logic [31:0]       alu_port_o,
  input  logic              alu_flag_overflow,
  input  logic              alu_flag_negative,
  input  logic              alu_flag_zero,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned PTR_W = (NREQ > 2) ? 2 : 1;
  // Candidate index needs one extra bit to hold last_grant+offset before wrap.
  localparam int unsigned CW    = PTR_W + 1;

  logic [PTR_W-1:0]      last_grant;
  logic [NREQ-1:0]       eligible;
  logic [NREQ-1:0]       grant;
  logic                  grant_any;
  logic [PTR_W-1:0]      grant_idx;
  logic [CW-1:0]         cand;
  logic                  stall;

  logic [NREQ-1:0]       rsp_valid_q;
  logic [NREQ-1:0][31:0] rsp_o_q;
  logic [NREQ-1:0][2:0]  rsp_flags_q;
  logic [CNT_W-1:0]      stall_cnt_q;

  // A slot is free if empty or being drained this cycle (allows pass-through).
  assign eligible = bus.req_valid & (~rsp_valid_q | bus.rsp_ready);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = CW'(last_grant) + CW'(k + 1);
      if (cand >= CW'(NREQ)) begin
        cand = cand - CW'(NREQ);
      end
      if (!grant_any && eligible[cand[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
    // Nothing is granted while reset is held.
    if (RST) begin
      grant_any = 1'b0;
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Drive the shared ALU from the granted requester, zeros when idle.
  always_comb begin
    alu_aluop  = 4'b0;
    alu_port_a = 32'b0;
    alu_port_b = 32'b0;
    if (grant_any) begin
      alu_aluop  = bus.req_aluop[grant_idx];
      alu_port_a = bus.req_a[grant_idx];
      alu_port_b = bus.req_b[grant_idx];
    end
  end

  assign stall = |(bus.req_valid & ~grant);

  // Response buffers, round-robin pointer and stall counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_valid_q <= '0;
      rsp_o_q     <= '0;
      rsp_flags_q <= '0;
      last_grant  <= PTR_W'(NREQ - 1);
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_o_q[i]     <= alu_port_o;
          rsp_flags_q[i] <= {alu_flag_overflow, alu_flag_negative, alu_flag_zero};
        end else if (bus.rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
      if (grant_any) begin
        last_grant <= grant_idx;
      end
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_o     = rsp_o_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the shared ALU, keeps a behavioural model of
// the arbiter (per-requester response slots, round-robin search, saturating
// stall count) checked every cycle, and runs directed scenarios with literal
// expectations.
module tb_alu_arbiter;
  localparam int unsigned NREQ  = 2;
  localparam int unsigned CNT_W = 4;
  localparam int          SAT   = (1 << CNT_W) - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_BAD  = 4'hF;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [3:0]       alu_aluop;
  logic [31:0]      alu_port_a;
  logic [31:0]      alu_port_b;
  logic [31:0]      alu_port_o;
  logic             alu_flag_overflow;
  logic             alu_flag_negative;
  logic             alu_flag_zero;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter_if #(.NREQ(NREQ)) bus ();

  alu_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .bus               (bus),
    .alu_aluop         (alu_aluop),
    .alu_port_a        (alu_port_a),
    .alu_port_b        (alu_port_b),
    .alu_port_o        (alu_port_o),
    .alu_flag_overflow (alu_flag_overflow),
    .alu_flag_negative (alu_flag_negative),
    .alu_flag_zero     (alu_flag_zero),
    .stall_cnt         (stall_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference ALU: returns {overflow, negative, zero, result}.
  function automatic logic [34:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] o;
    logic        ov;
    ov = 1'b0;
    case (op)
      OP_ADD: begin
        o  = a + b;
        ov = (a[31] == b[31]) && (o[31] != a[31]);
      end
      OP_SUB: begin
        o  = a - b;
        ov = (a[31] != b[31]) && (o[31] != a[31]);
      end
      OP_AND:  o = a & b;
      OP_OR:   o = a | b;
      OP_XOR:  o = a ^ b;
      OP_SLT:  o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: o = (a < b) ? 32'd1 : 32'd0;
      default: o = 32'd0;
    endcase
    return {ov, o[31], (o == 32'd0), o};
  endfunction

  always_comb begin
    {alu_flag_overflow, alu_flag_negative, alu_flag_zero, alu_port_o} =
      alu_fn(alu_aluop, alu_port_a, alu_port_b);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i] = v;
    bus.req_aluop[i] = op;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
  endtask

  // Behavioural model state.
  bit          m_valid [NREQ];
  logic [31:0] m_o     [NREQ];
  logic [2:0]  m_flags [NREQ];
  int          m_last  = NREQ - 1;
  int          m_stall = 0;

  // Per-cycle compare: inputs are driven on the falling edge and settle
  // before this samples, then the model advances to the next rising edge.
  initial begin : model
    int              g;
    int              idx;
    logic [NREQ-1:0] eg;
    logic [34:0]     r;
    bit              stalled;
    logic [3:0]      eop;
    logic [31:0]     ea;
    logic [31:0]     eb;
    for (int i = 0; i < NREQ; i++) begin
      m_valid[i] = 1'b0;
      m_o[i]     = '0;
      m_flags[i] = '0;
    end
    forever begin
      @(negedge CLK);
      #3;
      g = -1;
      if (!RST) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (g < 0 && bus.req_valid[idx] && (!m_valid[idx] || bus.rsp_ready[idx])) g = idx;
        end
      end
      eg  = '0;
      eop = 4'b0;
      ea  = 32'b0;
      eb  = 32'b0;
      if (g >= 0) begin
        eg[g] = 1'b1;
        eop   = bus.req_aluop[g];
        ea    = bus.req_a[g];
        eb    = bus.req_b[g];
      end
      check("model req_ready", 64'(bus.req_ready), 64'(eg));
      check("model alu_aluop", 64'(alu_aluop), 64'(eop));
      check("model alu_port_a", 64'(alu_port_a), 64'(ea));
      check("model alu_port_b", 64'(alu_port_b), 64'(eb));
      for (int i = 0; i < NREQ; i++) begin
        check("model rsp_valid", 64'(bus.rsp_valid[i]), 64'(m_valid[i]));
        check("model rsp_o", 64'(bus.rsp_o[i]), 64'(m_o[i]));
        check("model rsp_flags", 64'(bus.rsp_flags[i]), 64'(m_flags[i]));
      end
      check("model stall_cnt", 64'(stall_cnt), 64'(m_stall));

      if (RST) begin
        for (int i = 0; i < NREQ; i++) begin
          m_valid[i] = 1'b0;
          m_o[i]     = '0;
          m_flags[i] = '0;
        end
        m_last  = NREQ - 1;
        m_stall = 0;
      end else begin
        stalled = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
          if (bus.req_valid[i] && i != g) stalled = 1'b1;
          if (i == g) begin
            r          = alu_fn(bus.req_aluop[i], bus.req_a[i], bus.req_b[i]);
            m_valid[i] = 1'b1;
            m_o[i]     = r[31:0];
            m_flags[i] = r[34:32];
          end else if (bus.rsp_ready[i]) begin
            m_valid[i] = 1'b0;
          end
        end
        if (g >= 0) m_last = g;
        if (stalled && m_stall < SAT) m_stall++;
      end
    end
  end

  // Directed scenarios with hand-computed expectations.
  initial begin : stim
    bus.rsp_ready = 2'b11;
    set_req(0, 1'b1, OP_ADD, 32'd0, 32'd0);
    set_req(1, 1'b1, OP_ADD, 32'd0, 32'd0);

    // Reset with both requesters valid.
    @(negedge CLK); #4;
    check("reset req_ready", 64'(bus.req_ready), 64'd0);
    check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset rsp_o", 64'(bus.rsp_o), 64'd0);
    check("reset stall_cnt", 64'(stall_cnt), 64'd0);

    // Release: requester 0 first, single ADD 5+7.
    @(negedge CLK);
    RST = 1'b0;
    set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
    set_req(1, 1'b1, OP_ADD, 32'd1, 32'd1);
    #4;
    check("release grant", 64'(bus.req_ready), 64'b01);
    check("release alu_port_a", 64'(alu_port_a), 64'd5);

    @(negedge CLK);
    bus.req_valid[0] = 1'b0;
    #4;
    check("single rsp_valid0", 64'(bus.rsp_valid[0]), 64'd1);
    check("single rsp_o0", 64'(bus.rsp_o[0]), 64'd12);
    check("single flags0", 64'(bus.rsp_flags[0]), 64'b000);
    check("held req1 grant", 64'(bus.req_ready), 64'b10);

    @(negedge CLK);
    bus.req_valid = 2'b00;
    RST = 1'b1;
    #4;
    check("req1 rsp_o", 64'(bus.rsp_o[1]), 64'd2);

    @(negedge CLK);
    RST = 1'b0;
    #4;
    check("post-reset stall_cnt", 64'(stall_cnt), 64'd0);

    // Round-robin: both valid for six cycles.
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      set_req(0, 1'b1, OP_ADD, 32'd10, 32'd1);
      set_req(1, 1'b1, OP_ADD, 32'd20, 32'd2);
      #4;
      check("rr grant", 64'(bus.req_ready), (c % 2 == 0) ? 64'b01 : 64'b10);
    end
    @(negedge CLK);
    bus.req_valid[0] = 1'b0;
    set_req(1, 1'b1, OP_SUB, 32'd3, 32'd3);
    #4;
    check("rr stall_cnt", 64'(stall_cnt), 64'd6);
    check("sub grant", 64'(bus.req_ready), 64'b10);
    @(negedge CLK);
    bus.req_valid = 2'b00;
    #4;
    check("sub rsp_o1", 64'(bus.rsp_o[1]), 64'd0);
    check("sub flags1", 64'(bus.rsp_flags[1]), 64'b001);

    // Backpressure on requester 0.
    @(negedge CLK);
    bus.rsp_ready = 2'b10;
    set_req(0, 1'b1, OP_ADD, 32'd10, 32'd20);
    @(negedge CLK);
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    set_req(1, 1'b1, OP_XOR, 32'hF0, 32'h0F);
    #4;
    check("bp rsp_valid0", 64'(bus.rsp_valid[0]), 64'd1);
    check("bp rsp_o0", 64'(bus.rsp_o[0]), 64'd30);
    check("bp grant", 64'(bus.req_ready), 64'b10);
    repeat (2) begin
      @(negedge CLK); #4;
      check("bp grant hold", 64'(bus.req_ready), 64'b10);
      check("bp rsp_o0 hold", 64'(bus.rsp_o[0]), 64'd30);
    end
    @(negedge CLK);
    bus.rsp_ready = 2'b11;
    #4;
    check("pass-through grant", 64'(bus.req_ready), 64'b01);
    @(negedge CLK);
    bus.req_valid = 2'b00;
    #4;
    check("pass-through rsp_valid0", 64'(bus.rsp_valid[0]), 64'd1);
    check("pass-through rsp_o0", 64'(bus.rsp_o[0]), 64'd2);
    check("bp stall_cnt", 64'(stall_cnt), 64'd10);

    // Flags: signed overflow, SLT, unsupported code.
    @(negedge CLK);
    set_req(0, 1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge CLK);
    set_req(0, 1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    #4;
    check("ovf rsp_o0", 64'(bus.rsp_o[0]), 64'h8000_0000);
    check("ovf flags0", 64'(bus.rsp_flags[0]), 64'b110);
    @(negedge CLK);
    set_req(0, 1'b1, OP_BAD, 32'd5, 32'd5);
    #4;
    check("slt rsp_o0", 64'(bus.rsp_o[0]), 64'd1);
    check("slt flags0", 64'(bus.rsp_flags[0]), 64'b000);
    @(negedge CLK);
    bus.req_valid = 2'b00;
    #4;
    check("bad-op rsp_o0", 64'(bus.rsp_o[0]), 64'd0);
    check("bad-op flags0", 64'(bus.rsp_flags[0]), 64'b001);

    // Saturation: requester 1 blocked by its full response slot.
    @(negedge CLK);
    bus.rsp_ready = 2'b01;
    set_req(1, 1'b1, OP_ADD, 32'd1, 32'd2);
    repeat (20) @(negedge CLK);
    #4;
    check("sat stall_cnt", 64'(stall_cnt), 64'(SAT));
    check("sat rsp_valid1", 64'(bus.rsp_valid[1]), 64'd1);
    check("sat req_ready", 64'(bus.req_ready), 64'd0);

    // Reset with a buffered response pending.
    @(negedge CLK);
    RST = 1'b1;
    bus.req_valid = 2'b00;
    @(negedge CLK);
    RST = 1'b0;
    #4;
    check("mid-reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid-reset stall_cnt", 64'(stall_cnt), 64'd0);

    repeat (2) @(negedge CLK);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between NREQ requesters, e.g. the execute stage plus a multi-cycle helper unit.
- Each requester has a valid/ready request channel and a buffered valid/ready response channel.
- Arbitration is round-robin; one ALU operation is issued per cycle.
- Results are registered, giving one-cycle latency from request acceptance to response valid.

Parameters:
- NREQ, 2, number of requesters; supported range 2..4.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request accepted this cycle (grant).
- req_aluop  in  NREQx4  aluop_t from cpu_types_pkg, per requester.
- req_a  in  NREQx32  operand A, per requester.
- req_b  in  NREQx32  operand B, per requester.
- rsp_valid  out  NREQ  response valid, per requester.
- rsp_ready  in  NREQ  consumer accepts response, per requester.
- rsp_o  out  NREQx32  registered result.
- rsp_flags  out  NREQx3  registered {overflow, negative, zero}.
- alu_aluop  out  4  to ALU aluop.
- alu_port_a  out  32  to ALU port_a.
- alu_port_b  out  32  to ALU port_b.
- alu_port_o  in  32  from ALU port_o.
- alu_flag_overflow  in  1  from ALU.
- alu_flag_negative  in  1  from ALU.
- alu_flag_zero  in  1  from ALU.
- stall_cnt  out  CNT_W  cycles in which at least one valid request was not granted.

Behaviour:
- Reset values:
  - rsp_valid = 0; rsp_o = 0; rsp_flags = 0; stall_cnt = 0.
  - Round-robin pointer last_grant = NREQ-1, so requester 0 has top priority first.
  - Reset mid-operation discards all buffered responses. No response is issued for a request accepted in the reset cycle.
- Slot free for requester i: !rsp_valid[i] || rsp_ready[i]. This allows pass-through: a slot drained and refilled in the same cycle.
- Eligible: req_valid[i] && slot free[i].
- Grant selection (combinational):
  - Search eligible requesters starting at (last_grant+1) mod NREQ, wrapping.
  - Grant the first found; at most one grant per cycle.
  - req_ready is one-hot or zero.
  - req_ready[i] must not depend on req_valid of other requesters beyond this priority search.
- ALU drive:
  - With a grant to g: alu_aluop/alu_port_a/alu_port_b = req_aluop[g]/req_a[g]/req_b[g].
  - With no grant: drive 4'b0 and zero operands.
  - The ALU is purely combinational; results are sampled in the same cycle.
- On grant to g at edge k:
  - rsp_o[g] <= alu_port_o; rsp_flags[g] <= {overflow, negative, zero} from the ALU.
  - rsp_valid[g] <= 1; last_grant <= g.
- Response hold: while rsp_valid[i] && !rsp_ready[i], rsp_o[i] and rsp_flags[i] are stable.
- Response drain: rsp_valid[i] clears on rsp_ready[i] unless requester i is granted in the same cycle, in which case it stays 1 with new data.
- last_grant changes only on a grant. Idle cycles leave priority unchanged.
- Non-granted requesters: a requester with req_valid=1 but no grant must hold its request. The arbiter never drops an accepted request.
- stall_cnt increments by 1 in any cycle where some req_valid[i]=1 && !req_ready[i]. It saturates at all-ones; no wrap.
- Unsupported aluop codes pass through; the ALU returns 0 with flags per port_o.
- Throughput: one operation per cycle in aggregate. A single requester with rsp_ready held high gets one operation per cycle.

Test Plan:
- Reset: RST=1 for 2 cycles with req_valid all 1 -> req_ready=0 during reset, rsp_valid=0, rsp_o=0, stall_cnt=0. Release -> requester 0 granted first.
- Single op: req0 ADD a=5 b=7, rsp_ready=1 -> req_ready[0]=1 same cycle. Next cycle rsp_valid[0]=1, rsp_o[0]=12, flags=3'b000.
- Round-robin: both requesters valid for 6 cycles, rsp_ready all 1 -> grants 0,1,0,1,0,1. stall_cnt=6 at the end. Then SUB 3-3 on req1 -> rsp_o=0, zero flag=1.
- Backpressure: rsp_valid[0]=1 with rsp_ready[0]=0 and req0, req1 valid -> req1 granted every cycle and rsp_o[0] held stable. Raise rsp_ready[0] -> req0 granted that cycle (pass-through) and rsp_valid[0] stays 1 with new data.
- Overflow flags: ADD 0x7FFFFFFF+0x00000001 -> rsp_o=0x80000000, overflow=1, negative=1. SLT a=0xFFFFFFFF b=1 -> rsp_o=1.
- Saturation (CNT_W=4 for this test) and mid-operation reset: a requester stalled 20 cycles -> stall_cnt holds at 15. RST asserted while rsp_valid=1 -> rsp_valid=0 the next cycle.
